// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if
// Bundles the two requester ports and the cache-side request bus of the
// round-robin cache arbiter.
//   p0_* : core data side requester (req valid/ready/addr/data/type, rsp valid/data/err)
//   p1_* : host/debug side requester (same signal set as p0)
//   cache_req_* : operands and one-cycle issue pulse towards the cache
//   cache_O_data / cache_req_done : result and completion pulse from the cache
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' and cache's view (used by the surrounding system)
interface cache_arbiter_if;
    logic        p0_req_valid;
    logic        p0_req_ready;
    logic [31:0] p0_req_addr;
    logic [31:0] p0_req_data;
    logic [1:0]  p0_req_type;
    logic        p0_rsp_valid;
    logic [31:0] p0_rsp_data;
    logic        p0_rsp_err;

    logic        p1_req_valid;
    logic        p1_req_ready;
    logic [31:0] p1_req_addr;
    logic [31:0] p1_req_data;
    logic [1:0]  p1_req_type;
    logic        p1_rsp_valid;
    logic [31:0] p1_rsp_data;
    logic        p1_rsp_err;

    logic [31:0] cache_req_addr;
    logic [31:0] cache_req_data;
    logic [1:0]  cache_req_type;
    logic        cache_req_do;
    logic [31:0] cache_O_data;
    logic        cache_req_done;

    modport slave (
        input  p0_req_valid, p0_req_addr, p0_req_data, p0_req_type,
        output p0_req_ready, p0_rsp_valid, p0_rsp_data, p0_rsp_err,
        input  p1_req_valid, p1_req_addr, p1_req_data, p1_req_type,
        output p1_req_ready, p1_rsp_valid, p1_rsp_data, p1_rsp_err,
        output cache_req_addr, cache_req_data, cache_req_type, cache_req_do,
        input  cache_O_data, cache_req_done
    );

    modport master (
        output p0_req_valid, p0_req_addr, p0_req_data, p0_req_type,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_data, p0_rsp_err,
        output p1_req_valid, p1_req_addr, p1_req_data, p1_req_type,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_data, p1_rsp_err,
        input  cache_req_addr, cache_req_data, cache_req_type, cache_req_do,
        output cache_O_data, cache_req_done
    );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares the single-request cache between two requesters with round-robin
// arbitration. One request is in flight at a time: accept (ready pulse),
// issue (cache_req_do pulse), wait for cache_req_done, respond (rsp pulse).
// Illegal request types (2'b11) are answered locally with rsp_err and never
// reach the cache.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   bus (slave)   : requester ports p0/p1 and cache request bus
//   grant_count_0 : accepted requests on port 0 (wraps)
//   grant_count_1 : accepted requests on port 1 (wraps)
module cache_arbiter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_arbiter_if.slave       bus,
    output logic [CNT_WIDTH-1:0] grant_count_0,
    output logic [CNT_WIDTH-1:0] grant_count_1
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0] TYPE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last;
    logic        winner;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  type_q;
    logic [31:0] rsp_q;

    logic        any_valid;
    logic        sel;
    logic        accept;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic [1:0]  sel_type;

    // Winner selection: with both ports pending the one that did not win
    // last time goes; otherwise whichever single port is pending. Accept is
    // masked during reset so no ready pulse escapes while the block restarts.
    always_comb begin
        any_valid = bus.p0_req_valid | bus.p1_req_valid;
        if (bus.p0_req_valid && bus.p1_req_valid) begin
            sel = ~last;
        end else begin
            sel = bus.p1_req_valid;
        end
        sel_addr = sel ? bus.p1_req_addr : bus.p0_req_addr;
        sel_data = sel ? bus.p1_req_data : bus.p0_req_data;
        sel_type = sel ? bus.p1_req_type : bus.p0_req_type;
        accept   = (state == IDLE) && any_valid && !reset;
    end

    // Next-state and handshake outputs. The response of the winning port is
    // driven only in RESP; everything else stays at zero.
    always_comb begin
        state_next       = state;
        bus.p0_req_ready = 1'b0;
        bus.p1_req_ready = 1'b0;
        bus.p0_rsp_valid = 1'b0;
        bus.p0_rsp_data  = 32'h0;
        bus.p0_rsp_err   = 1'b0;
        bus.p1_rsp_valid = 1'b0;
        bus.p1_rsp_data  = 32'h0;
        bus.p1_rsp_err   = 1'b0;
        bus.cache_req_do = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    bus.p0_req_ready = ~sel;
                    bus.p1_req_ready = sel;
                    state_next = (sel_type == TYPE_ILLEGAL) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                bus.cache_req_do = 1'b1;
                state_next       = WAIT;
            end
            WAIT: begin
                if (bus.cache_req_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (winner) begin
                    bus.p1_rsp_valid = 1'b1;
                    bus.p1_rsp_data  = rsp_q;
                    bus.p1_rsp_err   = err_q;
                end else begin
                    bus.p0_rsp_valid = 1'b1;
                    bus.p0_rsp_data  = rsp_q;
                    bus.p0_rsp_err   = err_q;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latched request, response capture and grant counters. The
    // response register is cleared on accept so an illegal request returns 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last          <= 1'b1;
            winner        <= 1'b0;
            err_q         <= 1'b0;
            addr_q        <= 32'h0;
            data_q        <= 32'h0;
            type_q        <= 2'b00;
            rsp_q         <= 32'h0;
            grant_count_0 <= '0;
            grant_count_1 <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                last   <= sel;
                winner <= sel;
                addr_q <= sel_addr;
                data_q <= sel_data;
                type_q <= sel_type;
                err_q  <= (sel_type == TYPE_ILLEGAL);
                rsp_q  <= 32'h0;
                if (sel) begin
                    grant_count_1 <= grant_count_1 + CNT_ONE;
                end else begin
                    grant_count_0 <= grant_count_0 + CNT_ONE;
                end
            end
            if (state == WAIT && bus.cache_req_done) begin
                rsp_q <= bus.cache_O_data;
            end
        end
    end

    assign bus.cache_req_addr = addr_q;
    assign bus.cache_req_data = data_q;
    assign bus.cache_req_type = type_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
// Directed self-checking bench for cache_arbiter. Two instances share the
// same stimulus: dut (default 16-bit counters) and dut4 (4-bit counters, for
// the wrap check). A small cache model answers every cache_req_do with
// cache_req_done three cycles later; reads return stored write data or,
// for never-written addresses, {addr[15:0], 16'hC0DE}.
module tb_cache_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cache_arbiter_if bus();
    cache_arbiter_if bus4();

    logic [15:0] gc0;
    logic [15:0] gc1;
    logic [3:0]  gc0_4;
    logic [3:0]  gc1_4;

    cache_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .grant_count_0 (gc0),
        .grant_count_1 (gc1)
    );

    cache_arbiter #(.CNT_WIDTH(4)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus4),
        .grant_count_0 (gc0_4),
        .grant_count_1 (gc1_4)
    );

    assign bus4.p0_req_valid   = bus.p0_req_valid;
    assign bus4.p0_req_addr    = bus.p0_req_addr;
    assign bus4.p0_req_data    = bus.p0_req_data;
    assign bus4.p0_req_type    = bus.p0_req_type;
    assign bus4.p1_req_valid   = bus.p1_req_valid;
    assign bus4.p1_req_addr    = bus.p1_req_addr;
    assign bus4.p1_req_data    = bus.p1_req_data;
    assign bus4.p1_req_type    = bus.p1_req_type;
    assign bus4.cache_O_data   = bus.cache_O_data;
    assign bus4.cache_req_done = bus.cache_req_done;

    int compared = 0;
    int mismatched = 0;

    // Cache model, evaluated on the falling edge so its outputs are stable
    // around every rising edge.
    logic [31:0] mem [logic [31:0]];
    int          cd_cnt = 0;
    int          do_count = 0;
    logic        model_done = 1'b0;
    logic [31:0] model_data = 32'h0;
    logic        spur = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] pend_data = 32'h0;
    logic [1:0]  pend_type = 2'b00;

    assign bus.cache_req_done = model_done | spur;
    assign bus.cache_O_data   = model_data;

    always @(negedge clk) begin
        model_done = 1'b0;
        model_data = 32'h0;
        if (reset) begin
            cd_cnt = 0;
        end else begin
            if (cd_cnt != 0) begin
                cd_cnt--;
                if (cd_cnt == 0) begin
                    model_done = 1'b1;
                    if (pend_type == 2'b01) begin
                        mem[pend_addr] = pend_data;
                    end else if (pend_type == 2'b00) begin
                        if (mem.exists(pend_addr)) model_data = mem[pend_addr];
                        else model_data = {pend_addr[15:0], 16'hC0DE};
                    end
                end
            end
            if (bus.cache_req_do) begin
                do_count++;
                cd_cnt    = 3;
                pend_addr = bus.cache_req_addr;
                pend_data = bus.cache_req_data;
                pend_type = bus.cache_req_type;
            end
        end
    end

    logic [31:0] d;
    logic        e;
    bit          ob;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request on a port, waits (bounded) for accept and then for
    // the response. Also flags any activity on the other port's outputs.
    task automatic run_req(input bit port, input logic [1:0] typ,
                           input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata, output logic rerr,
                           output bit other_bad);
        bit got;
        other_bad = 1'b0;
        rdata = 32'h0;
        rerr = 1'b0;
        if (!port) begin
            bus.p0_req_valid = 1'b1; bus.p0_req_addr = addr;
            bus.p0_req_data = data;  bus.p0_req_type = typ;
        end else begin
            bus.p1_req_valid = 1'b1; bus.p1_req_addr = addr;
            bus.p1_req_data = data;  bus.p1_req_type = typ;
        end
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            if ((port ? bus.p1_req_ready : bus.p0_req_ready) === 1'b1) got = 1'b1;
            if ((port ? bus.p0_req_ready : bus.p1_req_ready) !== 1'b0) other_bad = 1'b1;
            step();
        end
        bus.p0_req_valid = 1'b0;
        bus.p1_req_valid = 1'b0;
        if (!got) begin
            compared++; mismatched++;
            $display("[TB] FAIL accept_timeout port %0d: no ready within 40 cycles", port);
            return;
        end
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            if ((port ? bus.p1_rsp_valid : bus.p0_rsp_valid) === 1'b1) begin
                got = 1'b1;
                rdata = port ? bus.p1_rsp_data : bus.p0_rsp_data;
                rerr  = port ? bus.p1_rsp_err : bus.p0_rsp_err;
            end
            if (port ? (bus.p0_rsp_valid !== 1'b0 || bus.p0_rsp_data !== 32'h0 || bus.p0_rsp_err !== 1'b0)
                     : (bus.p1_rsp_valid !== 1'b0 || bus.p1_rsp_data !== 32'h0 || bus.p1_rsp_err !== 1'b0))
                other_bad = 1'b1;
            if (!got) step();
        end
        if (!got) begin
            compared++; mismatched++;
            $display("[TB] FAIL rsp_timeout port %0d: no rsp_valid within 40 cycles", port);
        end
    endtask

    task automatic test_reset();
        bus.p0_req_valid = 1'b0; bus.p0_req_addr = 32'h0; bus.p0_req_data = 32'h0; bus.p0_req_type = 2'b00;
        bus.p1_req_valid = 1'b0; bus.p1_req_addr = 32'h0; bus.p1_req_data = 32'h0; bus.p1_req_type = 2'b00;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        compared++;
        if ({bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_valid, bus.p1_rsp_valid,
             bus.p0_rsp_err, bus.p1_rsp_err, bus.cache_req_do} !== 7'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                     {bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_valid, bus.p1_rsp_valid,
                      bus.p0_rsp_err, bus.p1_rsp_err, bus.cache_req_do});
        end
        compared++;
        if ({bus.cache_req_addr, bus.cache_req_data, bus.cache_req_type, bus.p0_rsp_data, bus.p1_rsp_data} !== 130'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: addr %h data %h type %b expected all 0",
                     bus.cache_req_addr, bus.cache_req_data, bus.cache_req_type);
        end
        compared++;
        if (gc0 !== 16'd0 || gc1 !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", gc0, gc1);
        end
    endtask

    task automatic test_single_read();
        int base;
        base = do_count;
        bus.p0_req_valid = 1'b1; bus.p0_req_addr = 32'h40; bus.p0_req_type = 2'b00; bus.p0_req_data = 32'h0;
        #1;
        compared++;
        if (bus.p0_req_ready !== 1'b1 || bus.p1_req_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL read_ready: got p0 %b p1 %b expected 1 0", bus.p0_req_ready, bus.p1_req_ready);
        end
        step();
        bus.p0_req_valid = 1'b0;
        compared++;
        if (bus.cache_req_do !== 1'b1 || bus.cache_req_addr !== 32'h40 || bus.cache_req_type !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL read_issue: do %b addr %h type %b expected 1 00000040 00",
                     bus.cache_req_do, bus.cache_req_addr, bus.cache_req_type);
        end
        for (int c = 2; c <= 4; c++) begin
            step();
            compared++;
            if (bus.p0_rsp_valid !== 1'b0 || bus.cache_req_do !== 1'b0 || bus.cache_req_addr !== 32'h40) begin
                mismatched++;
                $display("[TB] FAIL read_wait T+%0d: rsp %b do %b addr %h expected 0 0 00000040",
                         c, bus.p0_rsp_valid, bus.cache_req_do, bus.cache_req_addr);
            end
        end
        step();
        compared++;
        if (bus.p0_rsp_valid !== 1'b1 || bus.p0_rsp_data !== 32'h0040C0DE || bus.p0_rsp_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL read_rsp: valid %b data %h err %b expected 1 0040c0de 0",
                     bus.p0_rsp_valid, bus.p0_rsp_data, bus.p0_rsp_err);
        end
        compared++;
        if (gc0 !== 16'd1 || gc1 !== 16'd0 || bus.p1_rsp_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL read_count: gc0 %0d gc1 %0d p1_rsp %b expected 1 0 0", gc0, gc1, bus.p1_rsp_valid);
        end
        step();
        compared++;
        if (bus.p0_rsp_valid !== 1'b0 || bus.p0_rsp_data !== 32'h0 || do_count - base != 1) begin
            mismatched++;
            $display("[TB] FAIL read_after: rsp %b data %h issues %0d expected 0 0 1",
                     bus.p0_rsp_valid, bus.p0_rsp_data, do_count - base);
        end
    endtask

    task automatic test_round_robin();
        int seq [4];
        int n_grants;
        bit both;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        bus.p0_req_valid = 1'b1; bus.p0_req_addr = 32'h200; bus.p0_req_type = 2'b00;
        bus.p1_req_valid = 1'b1; bus.p1_req_addr = 32'h300; bus.p1_req_type = 2'b00;
        n_grants = 0;
        both = 1'b0;
        for (int c = 0; c < 80 && n_grants < 4; c++) begin
            #1;
            if (bus.p0_req_ready === 1'b1 && bus.p1_req_ready === 1'b1) both = 1'b1;
            if (bus.p0_req_ready === 1'b1) begin
                seq[n_grants] = 0; n_grants++;
            end else if (bus.p1_req_ready === 1'b1) begin
                seq[n_grants] = 1; n_grants++;
            end
            step();
        end
        bus.p0_req_valid = 1'b0;
        bus.p1_req_valid = 1'b0;
        compared++;
        if (n_grants != 4 || both) begin
            mismatched++;
            $display("[TB] FAIL rr_grants: got %0d grants dual_ready %b expected 4 0", n_grants, both);
        end
        for (int i = 0; i < n_grants; i++) begin
            compared++;
            if (seq[i] != (i % 2)) begin
                mismatched++;
                $display("[TB] FAIL rr_order[%0d]: got port %0d expected port %0d", i, seq[i], i % 2);
            end
        end
        repeat (8) step();
        compared++;
        if (gc0 !== 16'd2 || gc1 !== 16'd2) begin
            mismatched++;
            $display("[TB] FAIL rr_counts: got %0d/%0d expected 2/2", gc0, gc1);
        end
    endtask

    task automatic test_write_read();
        run_req(1'b1, 2'b01, 32'h100, 32'hDEAD_BEEF, d, e, ob);
        compared++;
        if (e !== 1'b0 || ob) begin
            mismatched++;
            $display("[TB] FAIL wr_rsp: err %b p0_activity %b expected 0 0", e, ob);
        end
        step();
        run_req(1'b1, 2'b00, 32'h100, 32'h0, d, e, ob);
        compared++;
        if (d !== 32'hDEAD_BEEF || e !== 1'b0 || ob) begin
            mismatched++;
            $display("[TB] FAIL rd_back: data %h err %b p0_activity %b expected deadbeef 0 0", d, e, ob);
        end
        compared++;
        if (gc0 !== 16'd2 || gc1 !== 16'd4) begin
            mismatched++;
            $display("[TB] FAIL wr_counts: got %0d/%0d expected 2/4", gc0, gc1);
        end
        step();
    endtask

    task automatic test_illegal();
        int base;
        base = do_count;
        bus.p0_req_valid = 1'b1; bus.p0_req_addr = 32'h80; bus.p0_req_type = 2'b11; bus.p0_req_data = 32'h55;
        #1;
        compared++;
        if (bus.p0_req_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ill_ready: got %b expected 1", bus.p0_req_ready);
        end
        step();
        compared++;
        if (bus.p0_rsp_valid !== 1'b1 || bus.p0_rsp_err !== 1'b1 || bus.p0_rsp_data !== 32'h0 ||
            bus.p0_req_ready !== 1'b0 || bus.cache_req_do !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ill_rsp: valid %b err %b data %h ready %b do %b expected 1 1 0 0 0",
                     bus.p0_rsp_valid, bus.p0_rsp_err, bus.p0_rsp_data, bus.p0_req_ready, bus.cache_req_do);
        end
        bus.p0_req_valid = 1'b0;
        bus.p0_req_type = 2'b00;
        step();
        compared++;
        if (bus.p0_rsp_valid !== 1'b0 || bus.p0_rsp_err !== 1'b0 || do_count != base || gc0 !== 16'd3) begin
            mismatched++;
            $display("[TB] FAIL ill_after: rsp %b err %b issues %0d gc0 %0d expected 0 0 0 3",
                     bus.p0_rsp_valid, bus.p0_rsp_err, do_count - base, gc0);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        bus.p0_req_valid = 1'b1; bus.p0_req_addr = 32'h40; bus.p0_req_type = 2'b00;
        step();
        bus.p0_req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        compared++;
        if ({bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_valid, bus.p1_rsp_valid, bus.cache_req_do} !== 5'b0 ||
            bus.cache_req_addr !== 32'h0 || gc0 !== 16'd0 || gc1 !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL abort_state: ctrl %b addr %h counts %0d/%0d expected 00000 0 0/0",
                     {bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_valid, bus.p1_rsp_valid, bus.cache_req_do},
                     bus.cache_req_addr, gc0, gc1);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.p0_rsp_valid !== 1'b0 || bus.p1_rsp_valid !== 1'b0 || bus.cache_req_do !== 1'b0) seen = 1'b1;
        end
        compared++;
        if (seen) begin
            mismatched++;
            $display("[TB] FAIL abort_quiet: got activity 1 expected 0");
        end
        run_req(1'b0, 2'b00, 32'h44, 32'h0, d, e, ob);
        compared++;
        if (d !== 32'h0044C0DE || e !== 1'b0 || gc0 !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL abort_fresh: data %h err %b gc0 %0d expected 0044c0de 0 1", d, e, gc0);
        end
        step();
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            run_req(1'b0, (i % 2) ? 2'b11 : 2'b00, 32'h10 + i, 32'h0, d, e, ob);
            if (i == 14) begin
                compared++;
                if (gc0_4 !== 4'd15) begin
                    mismatched++;
                    $display("[TB] FAIL wrap_pre: got %0d expected 15", gc0_4);
                end
            end
        end
        compared++;
        if (gc0_4 !== 4'd0 || gc0 !== 16'd16 || gc1_4 !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL wrap: cnt4 %0d cnt16 %0d cnt4_p1 %0d expected 0 16 0", gc0_4, gc0, gc1_4);
        end
        step();
        step();
    endtask

    task automatic test_spurious_done();
        bit seen;
        spur = 1'b1;
        step();
        spur = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bus.p0_rsp_valid !== 1'b0 || bus.p1_rsp_valid !== 1'b0 || bus.cache_req_do !== 1'b0 ||
                bus4.p0_rsp_valid !== 1'b0)
                seen = 1'b1;
            step();
        end
        compared++;
        if (seen) begin
            mismatched++;
            $display("[TB] FAIL spurious_done: got response activity 1 expected 0");
        end
        run_req(1'b0, 2'b00, 32'h48, 32'h0, d, e, ob);
        compared++;
        if (d !== 32'h0048C0DE || e !== 1'b0 || gc0_4 !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL spurious_after: data %h err %b cnt4 %0d expected 0048c0de 0 1", d, e, gc0_4);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_read();
        test_illegal();
        test_reset_mid_wait();
        test_wrap();
        test_spurious_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port round-robin arbiter that shares the single-request `cache` block between two requesters (port 0: core data side, port 1: host/debug side). It accepts one request at a time through a valid/ready handshake, issues it to the cache as a one-cycle `req_do` pulse with operands held stable, captures the cache result on `req_done`, and returns it to the granting port as a one-cycle response. It also rejects illegal request types locally and keeps per-port grant counters for bring-up visibility.

## Interface
- `CNT_WIDTH`, default 16: width of each grant counter.
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p0_req_valid` / `p1_req_valid`  in  1  request pending; must stay high with operands stable until accepted.
- `p0_req_ready` / `p1_req_ready`  out  1  one-cycle accept pulse; transfer occurs when valid & ready.
- `p0_req_addr` / `p1_req_addr`  in  32  byte address.
- `p0_req_data` / `p1_req_data`  in  32  write data.
- `p0_req_type` / `p1_req_type`  in  2  00 read, 01 write, 10 flush, 11 illegal.
- `p0_rsp_valid` / `p1_rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `p0_rsp_data` / `p1_rsp_data`  out  32  result, valid only with rsp_valid, else 0.
- `p0_rsp_err` / `p1_rsp_err`  out  1  illegal type, valid only with rsp_valid, else 0.
- `cache_req_addr`, `cache_req_data`  out  32  operands to cache.
- `cache_req_type`  out  2  type to cache.
- `cache_req_do`  out  1  one-cycle issue pulse.
- `cache_O_data`  in  32  cache result, meaningful while `cache_req_done`.
- `cache_req_done`  in  1  cache completion pulse.
- `grant_count_0`, `grant_count_1`  out  CNT_WIDTH  accepted requests per port.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any valid, select winner, pulse its ready, latch addr/data/type and winner id. Legal type -> ISSUE; type 11 -> RESP with err flag set, cache untouched.
- Round-robin: `last` register (reset = 1). Both valid -> port != `last` wins. One valid -> it wins. `last` updates to winner on every accept.
- ISSUE: `cache_req_do` = 1 for exactly this cycle -> WAIT.
- WAIT: on `cache_req_done`, capture `cache_O_data` into response register -> RESP; otherwise stay, no timeout.
- RESP: winner's rsp_valid = 1, rsp_data = captured data (0 for illegal), rsp_err = err flag; loser's rsp outputs 0 -> IDLE.
- `cache_req_addr/data/type` driven from latched registers; stable from ISSUE through WAIT; zero after reset until first accept.
- `cache_req_done` outside WAIT ignored.
- Counters increment by 1 on each accept for that port (illegal included); wrap to 0 at all-ones.
- Requests arriving while not in IDLE see ready low and must hold.

## Timing
- Reset (synchronous): state IDLE, `last` = 1, all outputs 0, latched operands/response 0, counters 0. Reset mid-transaction aborts; cache shares `reset` so both restart clean; no response pulse is emitted for the aborted request.
- Accept at cycle T -> `cache_req_do` at T+1 -> `cache_req_done` at T+1+k (k >= 1) -> rsp_valid at T+2+k -> next accept earliest T+3+k.
- Illegal type: accept at T, rsp_valid with err at T+1, next accept earliest T+2.
- At most one ready, one rsp_valid, one `cache_req_do` asserted per cycle.
- Issue never precedes the cycle after the prior `req_done` + 1, so the cache is always idle when `req_do` rises.

## Test plan
- Reset, p0 read 0x0000_0040 (cache read hit, `req_done` 3 cycles after `req_do`): ready at T, `cache_req_do` at T+1 with addr 0x40/type 00, p0_rsp_valid at T+5 with cached data, err 0, grant_count_0 = 1.
- p0 and p1 both valid from reset with reads: p0 granted first, then p1, then p0; grants alternate while both remain valid; counters equal after an even number of grants.
- p1 write 0xDEAD_BEEF to 0x100 then p1 read 0x100: read response data 0xDEAD_BEEF; p0 idle outputs stay 0.
- p0 type 11: ready at T, p0_rsp_valid and p0_rsp_err at T+1, rsp_data 0, `cache_req_do` never asserted.
- Assert reset while in WAIT: next cycle all outputs 0, state IDLE, counters 0, no rsp_valid; fresh p0 request then completes normally.
- Drive CNT_WIDTH = 4, 16 p0 grants: grant_count_0 wraps to 0; spurious `cache_req_done` injected in IDLE causes no response.
